// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the serial offset min-sum check-node unit.
// Pure definitions: no logic, no latency, no flow control.
package ldpc_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    // Largest magnitude representable in a w-bit two's-complement message
    function automatic int mag_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Beat-counter width; never collapse to zero bits for degree-1 builds
    function automatic int cnt_w(input int deg);
        return (deg > 1) ? $clog2(deg) : 1;
    endfunction

endpackage

// File: rtl/ldpc_cnu_minfind.sv
// Per-lane min1/min2/idx1/sign-product tracker with sign store and c2v output (offset under LDPC_CNU_OFFSET_EN).
// Latency: state updates on the accepting edge; c2v is combinational from stored state and idx.
// Backpressure: none internally; acc and en from the parent gate every update.
module ldpc_cnu_minfind
    import ldpc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEG_MAX = 24,
    parameter int CW      = cnt_w(DEG_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              acc,
    input  logic [CW-1:0]     idx,
    input  logic [DATA_W-1:0] msg,
    input  logic [DATA_W-2:0] offset,
    output logic              sprod_nxt,
    output logic [DATA_W-1:0] c2v
);

    localparam int MAG_MAX_I = mag_max(DATA_W);
    localparam logic [DATA_W-2:0] MAG_MAX = MAG_MAX_I[DATA_W-2:0];

    logic [DATA_W-2:0]  min1_q, min1_d, min2_q, min2_d;
    logic [CW-1:0]      idx1_q, idx1_d;
    logic               sprod_q, sprod_d;
    logic [DEG_MAX-1:0] sign_q, sign_d;

    logic [DATA_W-2:0]  min1_b, min2_b, mag_in, m_sel, m_off;
    logic [CW-1:0]      idx1_b;
    logic               sprod_b, sign_in, sign_out;
    logic [DATA_W-1:0]  neg, mag_ext;

    always_comb begin
        sign_in = msg[DATA_W-1];
        neg     = -msg;
        mag_in  = msg[DATA_W-2:0];
        if (sign_in) begin
            // The most negative code has no positive twin; clamp it to MAG_MAX
            mag_in = (msg[DATA_W-2:0] == '0) ? MAG_MAX : neg[DATA_W-2:0];
        end
        min1_b    = start ? MAG_MAX : min1_q;
        min2_b    = start ? MAG_MAX : min2_q;
        idx1_b    = start ? '0 : idx1_q;
        sprod_b   = start ? 1'b0 : sprod_q;
        sprod_nxt = sprod_b ^ sign_in;
    end

    always_comb begin
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx1_d  = idx1_q;
        sprod_d = sprod_q;
        sign_d  = sign_q;
        if (acc) begin
            min1_d  = min1_b;
            min2_d  = min2_b;
            idx1_d  = idx1_b;
            sprod_d = sprod_nxt;
            sign_d[idx] = sign_in;
            // Strict compares so a tie keeps the earliest index as idx1
            if (mag_in < min1_b) begin
                min2_d = min1_b;
                min1_d = mag_in;
                idx1_d = idx;
            end else if (mag_in < min2_b) begin
                min2_d = mag_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min1_q  <= '0;
            min2_q  <= '0;
            idx1_q  <= '0;
            sprod_q <= 1'b0;
            sign_q  <= '0;
        end else if (en) begin
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx1_q  <= idx1_d;
            sprod_q <= sprod_d;
            sign_q  <= sign_d;
        end
    end

`ifdef LDPC_CNU_OFFSET_EN
    always_comb begin
        m_sel = (idx == idx1_q) ? min2_q : min1_q;
        m_off = (m_sel > offset) ? (m_sel - offset) : '0;
    end
`else
    logic unused_offset;
    assign unused_offset = ^offset;
    always_comb begin
        m_sel = (idx == idx1_q) ? min2_q : min1_q;
        m_off = m_sel;
    end
`endif

    always_comb begin
        sign_out = sprod_q ^ sign_q[idx];
        mag_ext  = {1'b0, m_off};
        c2v      = sign_out ? -mag_ext : mag_ext;
    end

endmodule

// File: rtl/ldpc_cnu_serial.sv
// Serial multi-lane offset min-sum check-node unit (offset gated by LDPC_CNU_OFFSET_EN).
// Latency: first c2v beat valid the cycle after the last input beat is accepted.
// Backpressure: in_ready low during EMIT; output beats advance only on out_valid & out_ready & en.
module ldpc_cnu_serial
    import ldpc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEG_MAX = 24,
    parameter int LANES   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_W-2:0]       offset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] in_msg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [LANES*DATA_W-1:0] out_msg,
    output logic [LANES-1:0]        parity_ok,
    output logic                    ovf,
    output logic                    busy
);

    localparam int CW = cnt_w(DEG_MAX);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEG_MAX - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, last_idx_q, last_idx_d;
    logic                    ovf_q, ovf_d;
    logic [LANES-1:0]        parity_q, parity_d, sprod_nxt;
    logic [LANES*DATA_W-1:0] lane_c2v;
    logic                    in_acc, out_acc, row_end, row_start;

    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;
    // A full-degree beat closes the row even without in_last
    assign row_end   = in_acc & (in_last | (cnt_q == LAST_IDX));
    assign row_start = (state_q == ST_IDLE);
    assign parity_ok = parity_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (in_acc) state_d = row_end ? ST_EMIT : ST_COLLECT;
            ST_COLLECT: if (row_end) state_d = ST_EMIT;
            ST_EMIT:    if (out_acc && out_last) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_msg   = '0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE, ST_COLLECT: in_ready = en & ~rst;
            ST_EMIT: begin
                out_valid = en & ~rst;
                out_last  = (cnt_q == last_idx_q);
                out_msg   = lane_c2v;
            end
            default: ;
        endcase
    end

    // One counter indexes input beats while collecting and output beats while emitting
    always_comb begin
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        ovf_d      = ovf_q;
        parity_d   = parity_q;
        if (row_end) begin
            cnt_d      = '0;
            last_idx_d = cnt_q;
            ovf_d      = ~in_last;
            parity_d   = ~sprod_nxt;
        end else if (in_acc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (out_acc) begin
            cnt_d = out_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            last_idx_q <= '0;
            ovf_q      <= 1'b0;
            parity_q   <= '0;
        end else if (en) begin
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            ovf_q      <= ovf_d;
            parity_q   <= parity_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ldpc_cnu_minfind #(
            .DATA_W  (DATA_W),
            .DEG_MAX (DEG_MAX),
            .CW      (CW)
        ) u_minfind (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .start     (row_start),
            .acc       (in_acc),
            .idx       (cnt_q),
            .msg       (in_msg[i*DATA_W +: DATA_W]),
            .offset    (offset),
            .sprod_nxt (sprod_nxt[i]),
            .c2v       (lane_c2v[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_ldpc_cnu_serial.sv
// Scoreboard bench for ldpc_cnu_serial: two lanes, small DEG_MAX for overflow coverage.
// Expected c2v beats come from an exclude-self min / sign-product model pushed per accepted row.
module tb_ldpc_cnu_serial;

    localparam int DW     = 8;
    localparam int DEG    = 6;
    localparam int LN     = 2;
    localparam int MAGMAX = 127;

    logic            clk = 1'b0;
    logic            rst, en, in_valid, in_ready, in_last;
    logic            out_valid, out_ready, out_last, ovf, busy;
    logic [DW-2:0]   offset;
    logic [LN*DW-1:0] in_msg, out_msg;
    logic [LN-1:0]   parity_ok;

    always #5 clk = ~clk;

    ldpc_cnu_serial #(.DATA_W(DW), .DEG_MAX(DEG), .LANES(LN)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .offset    (offset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_msg   (out_msg),
        .parity_ok (parity_ok),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct packed {
        logic [LN*DW-1:0] msg;
        logic             last;
        logic [LN-1:0]    par;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   row_v[LN][DEG];
    bit   en_rand  = 1'b0;
    int   rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int smag(input int v);
        if (v == -(MAGMAX + 1)) return MAGMAX;
        return (v < 0) ? -v : v;
    endfunction

    // Each output is the min magnitude and sign product over the *other* beats of the row
    task automatic push_row(input int n, input bit ovfl, input int offv);
        int sub;
        sub = offv;
`ifndef LDPC_CNU_OFFSET_EN
        sub = 0;
`endif
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.msg  = '0;
            e.par  = '0;
            e.last = (k == n - 1);
            e.ovf  = ovfl;
            for (int l = 0; l < LN; l++) begin
                int m, val;
                bit s, p;
                m = MAGMAX; s = 1'b0; p = 1'b0;
                for (int j = 0; j < n; j++) begin
                    p ^= (row_v[l][j] < 0);
                    if (j != k) begin
                        if (smag(row_v[l][j]) < m) m = smag(row_v[l][j]);
                        s ^= (row_v[l][j] < 0);
                    end
                end
                m   = (m > sub) ? m - sub : 0;
                val = s ? -m : m;
                e.msg[l*DW +: DW] = val[DW-1:0];
                e.par[l] = ~p;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic set_row(input int l, input int a, input int b, input int c, input int d);
        row_v[l][0] = a; row_v[l][1] = b; row_v[l][2] = c; row_v[l][3] = d;
    endtask

    // Called at posedge+1; returns at posedge+1 with the row in EMIT
    task automatic send_row(input int n, input bit ovfl, input int offv);
        int t;
        bit a;
        if (offv != int'(offset)) begin
            t = 0;
            while (busy && t < 2000) begin
                @(posedge clk); #1; t++;
            end
            if (t >= 2000) check("idle_timeout", 1, 0);
            offset = offv[DW-2:0];
        end
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_last  = (!ovfl && k == n - 1);
            for (int l = 0; l < LN; l++) begin
                int tmp;
                tmp = row_v[l][k];
                in_msg[l*DW +: DW] = tmp[DW-1:0];
            end
            t = 0; a = 1'b0;
            while (!a && t < 2000) begin
                @(negedge clk); a = in_ready;
                @(posedge clk); #1; t++;
            end
            if (!a) begin
                check("in_accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        push_row(n, ovfl, offv);
        @(negedge clk);
        check("first_out_valid", out_valid, en);
        check("in_ready_emit", in_ready, 0);
        check("busy_emit", busy, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        en = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (en_rand && $urandom_range(0, 19) == 0) begin
                en = 1'b0;
                repeat (3) @(posedge clk);
                #1 en = 1'b1;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int l = 0; l < LN; l++)
                        check("out_msg", out_msg[l*DW +: DW], e.msg[l*DW +: DW]);
                    check("out_last", out_last, e.last);
                    check("parity_ok", parity_ok, e.par);
                    check("ovf", ovf, e.ovf);
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_msg = '0; offset = '0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_parity", parity_ok, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        set_row(0, 5, -3, 7, -10); set_row(1, -128, 20, 4, -4);
        send_row(4, 0, 0);
        send_row(4, 0, 2);
        send_row(4, 0, 4);
        set_row(0, -128, 20, 0, 0); set_row(1, 4, -4, 0, 0);
        send_row(2, 0, 0);
        set_row(0, 4, -4, 4, 0); set_row(1, -128, 20, 1, 0);
        send_row(3, 0, 0);
        set_row(0, 9, 0, 0, 0); set_row(1, -128, 0, 0, 0);
        send_row(1, 0, 3);
        for (int k = 0; k < DEG; k++) begin
            row_v[0][k] = $urandom_range(0, 255) - 128;
            row_v[1][k] = $urandom_range(0, 20) - 10;
        end
        send_row(DEG, 1, 0);
        send_row(DEG, 0, 1);

        // Asynchronous reset in the middle of emission discards the row
        rdy_mode = 1;
        set_row(0, 5, -3, 7, -10); set_row(1, 3, 3, -2, 9);
        send_row(4, 0, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_msg", out_msg, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_ovf", ovf, 0);
        @(posedge clk); #1 rst = 1'b0;
        send_row(4, 0, 0);

        en_rand = 1'b1;
        for (int r = 0; r < 60; r++) begin
            int n, offv;
            bit ovfl;
            rdy_mode = r % 3;
            n    = $urandom_range(1, DEG + 2);
            ovfl = (n > DEG);
            if (ovfl) n = DEG;
            for (int k = 0; k < n; k++)
                for (int l = 0; l < LN; l++) begin
                    case ($urandom_range(0, 3))
                        0:       row_v[l][k] = $urandom_range(0, 12) - 6;
                        1:       row_v[l][k] = -128;
                        default: row_v[l][k] = $urandom_range(0, 255) - 128;
                    endcase
                end
            offv = ($urandom_range(0, 1) == 0) ? int'(offset) : $urandom_range(0, 10);
            send_row(n, ovfl, offv);
        end

        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        check("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ldpc_cnu_serial.md
# ldpc_cnu_serial

Serial, multi-lane offset min-sum check-node unit for the layered LDPC decoder datapath. It accepts one variable-to-check message per lane per beat for a single check row of arbitrary degree up to DEG_MAX. It then replays the check-to-variable messages in the same order, together with a per-lane parity flag. It generalises the fixed single-row check update inside `ldpc_core` with these additions: a parametrised lane count and message width, a runtime offset, valid/ready streaming on both sides, and degree-overflow detection.

## Interface
- DATA_W, 8, two's-complement message width
- DEG_MAX, 24, maximum row degree (beats per row)
- LANES, 1, independent rows processed in lockstep (lift-parallel)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable; low freezes all state
- offset  in  DATA_W-1  min-sum offset magnitude, static during a row
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_last  in  1  final beat of row
- in_msg  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_last  out  1  final output beat of row
- out_msg  out  LANES*DATA_W  check-to-variable messages
- parity_ok  out  LANES  per lane: XOR of input signs == 0; valid while out_valid
- ovf  out  1  row forced-terminated at DEG_MAX; valid while out_valid
- busy  out  1  state != IDLE

## Operation
- FSM IDLE -> COLLECT (first input beat accepted) -> EMIT (last beat accepted) -> IDLE (handshake on out_last).
- IDLE/COLLECT: in_ready = en; out_valid = 0. EMIT: in_ready = 0; out_valid = en.
- Per lane, on each accepted beat k: sign_k = msg[MSB]; sign is stored in a DEG_MAX-deep bit array; mag = |msg|, with -2^(DATA_W-1) saturating to MAG_MAX = 2^(DATA_W-1)-1.
- min1/min2/idx1 tracking: initialised to MAG_MAX/MAG_MAX/0 at row start.
  - mag < min1: min2 <= min1, min1 <= mag, idx1 <= k.
  - else mag < min2: min2 <= mag.
  - Ties keep the first index.
- sprod = XOR of all signs in the row.
- Output beat k: m = (k == idx1) ? min2 : min1; m' = max(m - offset, 0); sign = sprod ^ sign_k. out = sign ? -m' : m'. Zero is always emitted as 0.
- Degree 1: output magnitude is MAG_MAX - offset (saturated at 0).
- Overflow: the DEG_MAX-th beat without in_last is treated as last, and ovf = 1 for that row. Further input waits in IDLE for the next row.
- ovf and parity_ok are registered at the COLLECT->EMIT transition and held through EMIT.

## Timing
- Reset values: state IDLE, in_ready 0 while rst is high, out_valid 0, out_last 0, out_msg 0, parity_ok 0, ovf 0, busy 0, beat counter 0.
- Last input accepted at edge t: out_valid = 1 with beat 0 registered at t+1.
- Each output beat advances only on out_valid & out_ready & en. Data holds otherwise.
- out_last is accepted at edge u: in_ready = 1 at u+1. There is no overlap, so throughput is 2*deg cycles per row.
- en low: in_ready and out_valid are driven 0, and no register changes.
- rst mid-row: immediately IDLE, outputs at their reset values, partial row discarded.

## Configuration
- LDPC_CNU_OFFSET_EN defined: offset subtraction as described.
- LDPC_CNU_OFFSET_EN undefined: pure min-sum (m' = m). The offset port remains and is ignored.

## Structure
- ldpc_pkg: DATA_W default, MAG_MAX function, FSM state enum, degree-counter width function ($clog2(DEG_MAX)).
- Sub-module ldpc_cnu_minfind: per-lane min1/min2/idx1/sprod tracker plus sign store. It is instantiated LANES times; the FSM and counter stay in ldpc_cnu_serial.

## Test plan
All scenarios use DATA_W=8, LANES=1, offset=0 and the macro defined unless stated otherwise.
- {5,-3,7,-10}, last on beat 3 -> out {3,-5,3,-3}, parity_ok 1, ovf 0, first out_valid one cycle after last accept.
- Same row with offset=2 -> {1,-3,1,-1}; with offset=4 -> {0,-1,0,0}; with the macro undefined and offset=4 -> {3,-5,3,-3}.
- {-128,20} -> {20,-127}, parity_ok 0 (saturation and sign product).
- Ties {4,-4,4} -> {-4,4,-4}, parity_ok 0.
- LANES=2, {5,-3,7,-10} and {-128,20} in parallel, with out_ready toggling every cycle and en low for 3 cycles mid-EMIT -> identical per-lane outputs, no drop or duplication.
- DEG_MAX=4, 6 beats without in_last -> 4 accepted, in_ready low after beat 3, 4 outputs, ovf 1. A rst pulse mid-EMIT -> out_valid 0 asynchronously, busy 0, next row decodes correctly.
